// File: rtl/seq_hit_monitor_if.sv
// Bundle of the monitor's control inputs and status outputs.
// The consumer of the detector pulse sits on the slave side.
interface seq_hit_monitor_if #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
);
    logic             en;
    logic             hit_in;
    logic [WIN_W-1:0] win_len;
    logic [CNT_W-1:0] thresh;
    logic             clr;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] win_count;
    logic             win_valid;
    logic             thresh_flag;
    logic             overflow;

    modport master (
        output en, hit_in, win_len, thresh, clr,
        input  hit_count, win_count, win_valid, thresh_flag, overflow
    );

    modport slave (
        input  en, hit_in, win_len, thresh, clr,
        output hit_count, win_count, win_valid, thresh_flag, overflow
    );
endinterface

// File: rtl/seq_hit_monitor.sv
// Counts sequence-detector match pulses over programmable windows and latches
// the per-window count with sticky threshold and overflow status.
module seq_hit_monitor #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    seq_hit_monitor_if.slave   mon
);
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state, w_state_next;
    logic [WIN_W-1:0] r_cyc_cnt, w_cyc_cnt_next;
    logic [WIN_W-1:0] r_win_len_q, w_win_len_q_next;
    logic [CNT_W-1:0] r_hit_count, w_hit_count_next;
    logic [CNT_W-1:0] r_win_count, w_win_count_next;
    logic             r_win_valid, w_win_valid_next;
    logic             r_thresh_flag, w_thresh_flag_next;
    logic             r_overflow, w_overflow_next;

    logic             w_saturated;
    logic             w_last;
    logic [CNT_W-1:0] w_hit_inc;

    assign w_saturated = (r_hit_count == CNT_MAX);
    assign w_hit_inc   = (mon.hit_in && !w_saturated) ? r_hit_count + CNT_W'(1) : r_hit_count;
    assign w_last      = (r_cyc_cnt == r_win_len_q - WIN_W'(1));

    always_comb begin
        w_state_next       = r_state;
        w_cyc_cnt_next     = r_cyc_cnt;
        w_win_len_q_next   = r_win_len_q;
        w_hit_count_next   = r_hit_count;
        w_win_count_next   = r_win_count;
        w_win_valid_next   = 1'b0;
        w_thresh_flag_next = r_thresh_flag;
        w_overflow_next    = r_overflow;

        if (mon.clr) begin
            // State is kept; a running window simply restarts from cycle 0.
            w_cyc_cnt_next     = '0;
            w_hit_count_next   = '0;
            w_win_count_next   = '0;
            w_thresh_flag_next = 1'b0;
            w_overflow_next    = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_cyc_cnt_next   = '0;
                    w_hit_count_next = '0;
                    if (mon.en && (mon.win_len != '0)) begin
                        w_win_len_q_next = mon.win_len;
                        w_state_next     = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!mon.en || (r_win_len_q == '0)) begin
                        w_state_next     = ST_IDLE;
                        w_cyc_cnt_next   = '0;
                        w_hit_count_next = '0;
                    end else begin
                        if (mon.hit_in && w_saturated)
                            w_overflow_next = 1'b1;
                        if (w_last) begin
                            // The last-cycle hit is folded into the latched count.
                            w_win_count_next = w_hit_inc;
                            w_win_valid_next = 1'b1;
                            if ((mon.thresh != '0) && (w_hit_inc >= mon.thresh))
                                w_thresh_flag_next = 1'b1;
                            w_hit_count_next = '0;
                            w_cyc_cnt_next   = '0;
                            w_win_len_q_next = mon.win_len;
                        end else begin
                            w_cyc_cnt_next   = r_cyc_cnt + WIN_W'(1);
                            w_hit_count_next = w_hit_inc;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cyc_cnt     <= '0;
            r_win_len_q   <= '0;
            r_hit_count   <= '0;
            r_win_count   <= '0;
            r_win_valid   <= 1'b0;
            r_thresh_flag <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cyc_cnt     <= w_cyc_cnt_next;
            r_win_len_q   <= w_win_len_q_next;
            r_hit_count   <= w_hit_count_next;
            r_win_count   <= w_win_count_next;
            r_win_valid   <= w_win_valid_next;
            r_thresh_flag <= w_thresh_flag_next;
            r_overflow    <= w_overflow_next;
        end
    end

    assign mon.hit_count   = r_hit_count;
    assign mon.win_count   = r_win_count;
    assign mon.win_valid   = r_win_valid;
    assign mon.thresh_flag = r_thresh_flag;
    assign mon.overflow    = r_overflow;
endmodule

// File: tb/tb_seq_hit_monitor.sv
// Self-checking bench for seq_hit_monitor: directed table, hand sequences for
// window boundaries/saturation/abort, then random traffic against a window model.
module tb_seq_hit_monitor;
    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    seq_hit_monitor_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) mon_if ();

    seq_hit_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon_if.slave)
    );

    always #5 clk = ~clk;

    // Window model: unbounded hit tally per window, saturation applied on read.
    bit m_run, m_valid, m_tf, m_ov;
    int m_pos, m_len, m_hits, m_wc;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic void model_step(input bit r, input bit e, input bit h,
                                       input int wl, input int th, input bit c);
        int total;
        if (r) begin
            m_run = 0; m_pos = 0; m_len = 0; m_hits = 0; m_wc = 0;
            m_valid = 0; m_tf = 0; m_ov = 0;
        end else if (c) begin
            m_pos = 0; m_hits = 0; m_wc = 0; m_valid = 0; m_tf = 0; m_ov = 0;
        end else if (!m_run) begin
            m_valid = 0; m_hits = 0; m_pos = 0;
            if (e && wl != 0) begin
                m_run = 1; m_len = wl;
            end
        end else if (!e || m_len == 0) begin
            m_run = 0; m_hits = 0; m_pos = 0; m_valid = 0;
        end else begin
            total = m_hits + int'(h);
            if (total > CMAX) m_ov = 1;
            if (m_pos == m_len - 1) begin
                m_wc = sat(total);
                m_valid = 1;
                if (th != 0 && m_wc >= th) m_tf = 1;
                m_hits = 0; m_pos = 0; m_len = wl;
            end else begin
                m_pos++;
                m_hits = total;
                m_valid = 0;
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        check("hit_count",   int'(mon_if.hit_count),   sat(m_hits));
        check("win_count",   int'(mon_if.win_count),   m_wc);
        check("win_valid",   int'(mon_if.win_valid),   int'(m_valid));
        check("thresh_flag", int'(mon_if.thresh_flag), int'(m_tf));
        check("overflow",    int'(mon_if.overflow),    int'(m_ov));
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic apply(input bit r, input bit e, input bit h, input int wl,
                         input int th, input bit c);
        rst            = r;
        mon_if.en      = e;
        mon_if.hit_in  = h;
        mon_if.win_len = WIN_W'(wl);
        mon_if.thresh  = CNT_W'(th);
        mon_if.clr     = c;
        model_step(r, e, h, wl, th, c);
        @(posedge clk);
        #1;
        cyc++;
        check_model();
    endtask

    typedef struct {
        bit en; bit hit; bit clr;
        int hc; int wc; bit v; bit tf; bit ov;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #5_000_000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [2:0] sh;
        bit       b, h;
        int       n_det;
        bit       r, e, c;
        int       wl, th;
        bit [6:0] stream;

        // Boundary table: win_len=4, thresh=1, hit on last cycle of window 0
        // and on the first cycle of window 1.
        tbl[0]  = '{1,0,0, 0,0,0,0,0};   // IDLE -> RUN
        tbl[1]  = '{1,0,0, 0,0,0,0,0};
        tbl[2]  = '{1,0,0, 0,0,0,0,0};
        tbl[3]  = '{1,0,0, 0,0,0,0,0};
        tbl[4]  = '{1,1,0, 0,1,1,1,0};   // last cycle hit latched
        tbl[5]  = '{1,1,0, 1,1,0,1,0};   // first cycle of next window
        tbl[6]  = '{1,0,0, 1,1,0,1,0};
        tbl[7]  = '{1,0,0, 1,1,0,1,0};
        tbl[8]  = '{1,0,0, 0,1,1,1,0};
        tbl[9]  = '{0,0,0, 0,1,0,1,0};   // abort, status retained
        tbl[10] = '{0,0,1, 0,0,0,0,0};   // clr

        mon_if.en = 0; mon_if.hit_in = 0; mon_if.win_len = '0;
        mon_if.thresh = '0; mon_if.clr = 0;
        model_step(1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hit_count", int'(mon_if.hit_count), 0);
        check("reset_win_count", int'(mon_if.win_count), 0);
        check("reset_flags", int'({mon_if.win_valid, mon_if.thresh_flag, mon_if.overflow}), 0);

        for (int i = 0; i < 11; i++) begin
            apply(0, tbl[i].en, tbl[i].hit, 4, 1, tbl[i].clr);
            check($sformatf("tbl%0d_hit_count", i), int'(mon_if.hit_count), tbl[i].hc);
            check($sformatf("tbl%0d_win_count", i), int'(mon_if.win_count), tbl[i].wc);
            check($sformatf("tbl%0d_win_valid", i), int'(mon_if.win_valid), int'(tbl[i].v));
            check($sformatf("tbl%0d_thresh", i), int'(mon_if.thresh_flag), int'(tbl[i].tf));
            check($sformatf("tbl%0d_overflow", i), int'(mon_if.overflow), int'(tbl[i].ov));
        end

        // win_len=8, hits on RUN cycles 1,4,7.
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 8, 0, 0);
        for (int c8 = 0; c8 < 8; c8++) begin
            apply(0, 1, (c8 == 1 || c8 == 4 || c8 == 7), 8, 0, 0);
            if (c8 == 6) check("w8_valid_early", int'(mon_if.win_valid), 0);
        end
        check("w8_win_count", int'(mon_if.win_count), 3);
        check("w8_win_valid", int'(mon_if.win_valid), 1);
        check("w8_hit_count", int'(mon_if.hit_count), 0);
        apply(0, 1, 0, 8, 0, 0);
        check("w8_valid_drop", int'(mon_if.win_valid), 0);

        // Serial 1011011 through a behavioural 1011 overlapping detector.
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 16, 0, 0);
        stream = 7'b1011011;
        sh = '0; n_det = 0;
        for (int c16 = 0; c16 < 16; c16++) begin
            b = (c16 < 7) ? stream[6 - c16] : 1'b0;
            h = ({sh, b} == 4'b1011);
            n_det += int'(h);
            sh = {sh[1:0], b};
            apply(0, 1, h, 16, 0, 0);
        end
        check("det_pulses", n_det, 2);
        check("det_win_count", int'(mon_if.win_count), 2);

        // Saturation and sticky overflow.
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 400, 0, 0);
        for (int k = 0; k < 400; k++) apply(0, 1, (k < 300), 400, 0, 0);
        check("sat_win_count", int'(mon_if.win_count), 255);
        check("sat_overflow", int'(mon_if.overflow), 1);
        for (int k = 0; k < 400; k++) apply(0, 1, 0, 400, 0, 0);
        check("sat_next_win", int'(mon_if.win_count), 0);
        check("sat_ovf_sticky", int'(mon_if.overflow), 1);
        apply(0, 1, 0, 400, 0, 1);
        check("sat_clr_ovf", int'(mon_if.overflow), 0);
        check("sat_clr_wc", int'(mon_if.win_count), 0);

        // Threshold flag.
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 4, 3, 0);
        for (int k = 0; k < 4; k++) begin
            apply(0, 1, (k < 3), 4, 3, 0);
            if (k == 2) check("th_not_yet", int'(mon_if.thresh_flag), 0);
        end
        check("th_set", int'(mon_if.thresh_flag), 1);
        check("th_valid", int'(mon_if.win_valid), 1);
        for (int k = 0; k < 4; k++) apply(0, 1, 0, 4, 3, 0);
        check("th_sticky", int'(mon_if.thresh_flag), 1);
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 4, 0, 0);
        for (int k = 0; k < 4; k++) apply(0, 1, 1, 4, 0, 0);
        check("th_disabled", int'(mon_if.thresh_flag), 0);
        check("th_disabled_wc", int'(mon_if.win_count), 4);

        // Abort with en=0 at cycle 5 after 2 hits; then reset mid-RUN.
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 8, 0, 0);
        for (int k = 0; k < 8; k++) apply(0, 1, (k == 3), 8, 0, 0);
        for (int k = 0; k < 5; k++) apply(0, 1, (k < 2), 8, 0, 0);
        check("abort_pre_hc", int'(mon_if.hit_count), 2);
        apply(0, 0, 1, 8, 0, 0);
        check("abort_hc", int'(mon_if.hit_count), 0);
        check("abort_valid", int'(mon_if.win_valid), 0);
        check("abort_wc_kept", int'(mon_if.win_count), 1);
        apply(0, 1, 0, 8, 0, 0);
        for (int k = 0; k < 3; k++) apply(0, 1, 1, 8, 0, 0);
        apply(1, 1, 1, 8, 0, 0);
        check("rst_hc", int'(mon_if.hit_count), 0);
        check("rst_wc", int'(mon_if.win_count), 0);
        apply(0, 1, 1, 8, 0, 0);
        check("rst_idle_ignores_hit", int'(mon_if.hit_count), 0);

        // win_len=1: every RUN cycle closes a window.
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 1, 0, 0);
        apply(0, 1, 1, 1, 0, 0);
        check("w1_wc_a", int'(mon_if.win_count), 1);
        apply(0, 1, 0, 1, 0, 0);
        check("w1_wc_b", int'(mon_if.win_count), 0);
        check("w1_valid", int'(mon_if.win_valid), 1);

        // Random traffic.
        wl = 3; th = 2;
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 29) == 0) wl = $urandom_range(0, 6);
            if ($urandom_range(0, 49) == 0) th = $urandom_range(0, 4);
            apply(r, e, 1'($urandom_range(0, 1)), wl, th, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
